// File: rtl/dmem_responder_if.sv
// Request/response bus between the MEM stage and the data-memory responder.
// The master drives requests and accepts responses; the slave is the memory.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data memory for the MEM stage. One request is outstanding at a
// time; the access itself happens on the edge that enters RESP, after LATENCY
// wait states, and the registered result is held until the consumer takes it.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);

  localparam int         IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  wait_cnt;

  logic        lat_write;
  logic        lat_unsigned;
  logic [1:0]  lat_size;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic        req_ready_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        do_access;
  logic        acc_write;
  logic        acc_unsigned;
  logic [1:0]  acc_size;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;

  logic [IDX_W-1:0] word_idx;
  logic             out_of_range;
  logic [31:0]      rd_word;
  logic [15:0]      sel16;
  logic [3:0]       lane_en;
  logic [31:0]      wdata_rep;
  logic [31:0]      load_data;
  logic             misaligned;
  logic             access_err;
  logic [31:0]      access_rdata;

  assign accept    = reset && (state == IDLE) && bus.req_valid;
  assign do_access = (LATENCY == 0) ? accept
                                    : (reset && (state == WAIT) && (wait_cnt <= 4'd1));

  // With zero wait states the access happens on the accept edge, so the live
  // request is used; otherwise the copy latched at accept time is used.
  always_comb begin
    acc_write    = lat_write;
    acc_unsigned = lat_unsigned;
    acc_size     = lat_size;
    acc_addr     = lat_addr;
    acc_wdata    = lat_wdata;
    if (state == IDLE) begin
      acc_write    = bus.req_write;
      acc_unsigned = bus.req_unsigned;
      acc_size     = bus.req_size;
      acc_addr     = bus.req_addr;
      acc_wdata    = bus.req_wdata;
    end
  end

  assign word_idx     = acc_addr[IDX_W+1:2];
  assign out_of_range = {2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS);
  assign rd_word      = out_of_range ? 32'h0 : mem[word_idx];

  // Decode size/alignment into byte lanes, replicated store data, extended load data and fault.
  always_comb begin
    lane_en    = 4'b0000;
    wdata_rep  = acc_wdata;
    load_data  = 32'h0;
    misaligned = 1'b0;
    sel16      = 16'(rd_word >> {acc_addr[1:0], 3'b000});
    case (acc_size)
      2'b00: begin
        lane_en   = 4'b0001 << acc_addr[1:0];
        wdata_rep = {4{acc_wdata[7:0]}};
        load_data = acc_unsigned ? {24'h0, sel16[7:0]} : {{24{sel16[7]}}, sel16[7:0]};
      end
      2'b01: begin
        misaligned = acc_addr[0];
        lane_en    = acc_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{acc_wdata[15:0]}};
        load_data  = acc_unsigned ? {16'h0, sel16} : {{16{sel16[15]}}, sel16};
      end
      2'b10: begin
        misaligned = |acc_addr[1:0];
        lane_en    = 4'b1111;
        load_data  = rd_word;
      end
      default: misaligned = 1'b1;
    endcase
    access_err   = misaligned || out_of_range;
    access_rdata = (access_err || acc_write) ? 32'h0 : load_data;
  end

  // Array write: only enabled lanes of a fault-free store, never cleared by reset.
  always_ff @(posedge clk) begin
    if (do_access && acc_write && !access_err) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  // Control FSM: accept, count wait states, then hold the response until taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      wait_cnt     <= 4'd0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 32'h0;
      rsp_err_q    <= 1'b0;
      lat_write    <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_size     <= 2'b00;
      lat_addr     <= 32'h0;
      lat_wdata    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            lat_write    <= bus.req_write;
            lat_unsigned <= bus.req_unsigned;
            lat_size     <= bus.req_size;
            lat_addr     <= bus.req_addr;
            lat_wdata    <= bus.req_wdata;
            wait_cnt     <= LAT;
            req_ready_q  <= 1'b0;
            if (LATENCY == 0) begin
              state       <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= access_rdata;
              rsp_err_q   <= access_err;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (wait_cnt <= 4'd1) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= access_rdata;
            rsp_err_q   <= access_err;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a byte-array model predicts every response of the
// LATENCY=2 instance cycle by cycle; a second LATENCY=0 instance is checked
// for back-to-back operation.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic clk;
  logic reset;

  dmem_responder_if bus();
  dmem_responder_if bus0();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [7:0] mem_b [0:4*DEPTH-1];

  // Free-running clock and edge counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Absolute time limit so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endfunction

  // Memory semantics from first principles: little-endian byte array, natural alignment.
  task automatic modelAccess(input logic w, input logic [1:0] sz, input logic u,
                             input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] rd, output logic e);
    int nb;
    logic [31:0] v;
    nb = 1 << sz;
    e  = (sz == 2'b11) || ((a % 32'(nb)) != 0) || (a >= 32'(4*DEPTH));
    rd = 32'h0;
    if (!e) begin
      if (w) begin
        for (int i = 0; i < nb; i++) mem_b[a + 32'(i)] = d[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < nb; i++) v = v | (32'(mem_b[a + 32'(i)]) << (8*i));
        if (!u && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
        rd = v;
      end
    end
  endtask

  // Compare process: predicts handshake timing and data for the LATENCY=2 instance every cycle
  bit          busy = 0, acc_pending = 0, hs_pending = 0, need_eval = 0, exp_valid;
  int          age = 0;
  logic        c_write, c_uns, exp_err;
  logic [1:0]  c_size;
  logic [31:0] c_addr, c_wdata, exp_rdata;

  always @(negedge clk) begin
    if (!reset) begin
      busy = 0; acc_pending = 0; hs_pending = 0; need_eval = 0;
      checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd1);
      checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      checkOutput("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
      checkOutput("reset_rsp_err",   32'(bus.rsp_err),  32'd0);
    end else begin
      if (hs_pending) busy = 0;
      if (acc_pending) begin
        busy = 1; age = 0; need_eval = 1;
      end else if (busy && age < 1000) begin
        age++;
      end
      if (busy && age == LAT && need_eval) begin
        modelAccess(c_write, c_size, c_uns, c_addr, c_wdata, exp_rdata, exp_err);
        need_eval = 0;
      end
      exp_valid = busy && (age >= LAT);
      checkOutput("req_ready", 32'(bus.req_ready), 32'(!busy));
      checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
      if (exp_valid) begin
        checkOutput("rsp_rdata", bus.rsp_rdata, exp_rdata);
        checkOutput("rsp_err",   32'(bus.rsp_err), 32'(exp_err));
      end
      acc_pending = bus.req_valid && !busy;
      hs_pending  = exp_valid && bus.rsp_ready;
      if (acc_pending) begin
        c_write = bus.req_write; c_uns = bus.req_unsigned; c_size = bus.req_size;
        c_addr  = bus.req_addr;  c_wdata = bus.req_wdata;
      end
    end
  end

  task automatic scrambleReq();
    bus.req_write    = 1'($urandom);
    bus.req_size     = 2'($urandom);
    bus.req_unsigned = 1'($urandom);
    bus.req_addr     = $urandom;
    bus.req_wdata    = $urandom;
  endtask

  // One complete transaction on the LATENCY=2 instance; called at posedge+1
  task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic u,
                               input logic [31:0] a, input logic [31:0] d, input int stall,
                               output logic [31:0] rd, output logic e, output int edges);
    int k;
    int c0;
    rd = 32'h0; e = 1'b0; edges = 0;
    bus.req_write = w; bus.req_size = sz; bus.req_unsigned = u;
    bus.req_addr  = a; bus.req_wdata = d; bus.req_valid = 1'b1;
    bus.rsp_ready = (stall == 0);
    c0 = cyc;
    k  = 0;
    @(negedge clk);
    while (!bus.req_ready && k < 40) begin @(negedge clk); k++; end
    if (!bus.req_ready) begin
      checkOutput("accept_timeout", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    scrambleReq();
    k = 0;
    @(negedge clk);
    while (!bus.rsp_valid && k < 40) begin @(negedge clk); k++; end
    if (!bus.rsp_valid) begin
      checkOutput("rsp_timeout", 32'(bus.rsp_valid), 32'd1);
      bus.rsp_ready = 1'b1;
      return;
    end
    edges = cyc - c0;
    rd    = bus.rsp_rdata;
    e     = bus.rsp_err;
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1;
      bus.rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  logic [31:0] rd, a;
  logic        e;
  logic [1:0]  sz;
  int          ed, k;

  initial begin
    reset = 1'b0;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
    bus.req_addr  = 32'h0; bus.req_wdata = 32'h0; bus.rsp_ready = 1'b1;
    bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_size = 2'b10; bus0.req_unsigned = 1'b0;
    bus0.req_addr  = 32'h0; bus0.req_wdata = 32'h0; bus0.rsp_ready = 1'b1;

    // Reset held with a request pending
    repeat (3) @(posedge clk);
    #1;
    checkOutput("hold_reset_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("hold_reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    reset = 1'b1;

    // First request right after release; response LATENCY+1 edges after it is driven
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h0, 32'hC0DE0000, 0, rd, e, ed);
    checkOutput("first_latency_edges", 32'(ed), 32'(LAT + 1));
    checkOutput("first_store_err", 32'(e), 32'd0);

    // Known contents for the region used below
    for (int i = 1; i < 64; i++)
      applyStimulus(1'b1, 2'b10, 1'b0, 32'(4*i), 32'hC0DE0000 | 32'(4*i), 0, rd, e, ed);

    $display("[TB] word round-trip and sub-word lanes");
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, rd, e, ed);
    checkOutput("store_word_rdata", rd, 32'h0);
    checkOutput("store_word_err", 32'(e), 32'd0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, rd, e, ed);
    checkOutput("load_word_rdata", rd, 32'hDEADBEEF);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h13, 32'h12345680, 0, rd, e, ed);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0, rd, e, ed);
    checkOutput("load_byte_signed", rd, 32'hFFFFFF80);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0, rd, e, ed);
    checkOutput("load_byte_unsigned", rd, 32'h00000080);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, rd, e, ed);
    checkOutput("load_word_after_byte", rd, 32'h80ADBEEF);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 0, rd, e, ed);
    checkOutput("load_half_signed", rd, 32'hFFFF80AD);

    $display("[TB] error cases");
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 0, rd, e, ed);
    checkOutput("half_misaligned_err", 32'(e), 32'd1);
    checkOutput("half_misaligned_rdata", rd, 32'h0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h16, 32'h12345678, 0, rd, e, ed);
    checkOutput("word_misaligned_err", 32'(e), 32'd1);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 0, rd, e, ed);
    checkOutput("word_after_bad_store", rd, 32'hC0DE0014);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'(4*DEPTH), 32'h0, 0, rd, e, ed);
    checkOutput("out_of_range_err", 32'(e), 32'd1);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h8, 32'h0, 0, rd, e, ed);
    checkOutput("illegal_size_err", 32'(e), 32'd1);

    $display("[TB] back-pressure");
    bus.req_write = 1'b0; bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
    bus.req_addr  = 32'h10; bus.req_valid = 1'b1; bus.rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp_ready_before_accept", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    scrambleReq();
    k = 0;
    @(negedge clk);
    while (!bus.rsp_valid && k < 40) begin @(negedge clk); k++; end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      scrambleReq();
      bus.req_valid = 1'b1;
      @(negedge clk);
      checkOutput("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      checkOutput("bp_rsp_rdata", bus.rsp_rdata, 32'h80ADBEEF);
      checkOutput("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp_release_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("bp_release_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;

    $display("[TB] reset during wait states");
    bus.req_write = 1'b1; bus.req_size = 2'b10; bus.req_addr = 32'h20;
    bus.req_wdata = 32'h11111111; bus.req_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    reset = 1'b0;
    #1;
    checkOutput("midreset_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("midreset_rsp_rdata", bus.rsp_rdata, 32'h0);
    checkOutput("midreset_rsp_err",   32'(bus.rsp_err),  32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0, rd, e, ed);
    checkOutput("load_after_dropped_store", rd, 32'hC0DE0020);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 150; n++) begin
      k  = $urandom_range(0, 15);
      sz = (k < 5) ? 2'b00 : (k < 10) ? 2'b01 : (k < 15) ? 2'b10 : 2'b11;
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 7) != 0 && sz != 2'b11) a = a & ~((32'd1 << sz) - 32'd1);
      if ($urandom_range(0, 15) == 0) a = 32'd1024 + 32'($urandom_range(0, 4000));
      if ($urandom_range(0, 31) == 0) a = $urandom;
      applyStimulus(1'($urandom), sz, 1'($urandom), a, $urandom,
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, rd, e, ed);
    end

    $display("[TB] zero wait states, back-to-back");
    bus0.req_write = 1'b1; bus0.req_size = 2'b10; bus0.req_addr = 32'h40;
    bus0.req_wdata = 32'hCAFEF00D; bus0.req_valid = 1'b1; bus0.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus0.req_write = 1'b0; bus0.req_wdata = 32'h0;
    @(negedge clk);
    checkOutput("l0_store_rsp_valid", 32'(bus0.rsp_valid), 32'd1);
    checkOutput("l0_store_rdata",     bus0.rsp_rdata, 32'h0);
    checkOutput("l0_store_err",       32'(bus0.rsp_err), 32'd0);
    checkOutput("l0_store_req_ready", 32'(bus0.req_ready), 32'd0);
    @(negedge clk);
    checkOutput("l0_gap_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    checkOutput("l0_gap_req_ready", 32'(bus0.req_ready), 32'd1);
    @(negedge clk);
    checkOutput("l0_load_rsp_valid", 32'(bus0.rsp_valid), 32'd1);
    checkOutput("l0_load_rdata",     bus0.rsp_rdata, 32'hCAFEF00D);
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("l0_end_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    checkOutput("l0_end_req_ready", 32'(bus0.req_ready), 32'd1);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
